// File: rtl/load_store_unit.sv
// RV32I load/store stage: decodes size and alignment, steers byte lanes onto a
// word-wide req/ack memory port, and extends load results.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

  logic [1:0]  state_r;
  logic [7:0]  cnt_r;
  logic        is_store_r;
  logic [2:0]  funct3_r;
  logic [1:0]  addr_lo_r;

  logic        illegal_s;
  logic        misaligned_s;
  logic [3:0]  wmask_s;
  logic [31:0] wdata_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] load_ext_s;

  // Request-side decode: legality, alignment and write-lane steering.
  always_comb begin
    illegal_s    = 1'b0;
    misaligned_s = 1'b0;
    wmask_s      = 4'b0000;
    wdata_s      = 32'h0000_0000;

    case (funct3)
      3'b000, 3'b001, 3'b010: illegal_s = 1'b0;
      3'b100, 3'b101:         illegal_s = is_store;
      default:                illegal_s = 1'b1;
    endcase

    case (funct3[1:0])
      2'b01:   misaligned_s = addr[0];
      2'b10:   misaligned_s = (addr[1:0] != 2'b00);
      default: misaligned_s = 1'b0;
    endcase

    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          wmask_s = 4'b0001 << addr[1:0];
          wdata_s = {4{store_data[7:0]}};
        end
        2'b01: begin
          wmask_s = addr[1] ? 4'b1100 : 4'b0011;
          wdata_s = {2{store_data[15:0]}};
        end
        default: begin
          wmask_s = 4'b1111;
          wdata_s = store_data;
        end
      endcase
    end else begin
      wmask_s = 4'b0000;
      wdata_s = 32'h0000_0000;
    end
  end

  // Response-side lane extraction and sign/zero extension of the read word.
  always_comb begin
    byte_s     = mem_rdata[{addr_lo_r, 3'b000} +: 8];
    half_s     = mem_rdata[{addr_lo_r[1], 4'b0000} +: 16];
    load_ext_s = mem_rdata;
    case (funct3_r)
      3'b000:  load_ext_s = {{24{byte_s[7]}}, byte_s};
      3'b001:  load_ext_s = {{16{half_s[15]}}, half_s};
      3'b100:  load_ext_s = {24'h00_0000, byte_s};
      3'b101:  load_ext_s = {16'h0000, half_s};
      default: load_ext_s = mem_rdata;
    endcase
  end

  // Access sequencer: all outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= 8'd0;
      is_store_r  <= 1'b0;
      funct3_r    <= 3'b000;
      addr_lo_r   <= 2'b00;
      busy        <= 1'b0;
      done        <= 1'b0;
      load_data   <= 32'h0000_0000;
      fault       <= 1'b0;
      fault_cause <= 2'b00;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'h0000_0000;
      mem_wmask   <= 4'b0000;
      mem_wdata   <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          done        <= 1'b0;
          fault       <= 1'b0;
          fault_cause <= 2'b00;
          busy        <= 1'b0;
          if (start) begin
            is_store_r <= is_store;
            funct3_r   <= funct3;
            addr_lo_r  <= addr[1:0];
            busy       <= 1'b1;
            if (illegal_s || misaligned_s) begin
              // Faults complete immediately without touching memory.
              state_r     <= DONE;
              done        <= 1'b1;
              fault       <= 1'b1;
              fault_cause <= illegal_s ? 2'b10 : 2'b01;
              if (!is_store) begin
                load_data <= 32'h0000_0000;
              end
            end else begin
              state_r   <= REQ;
              cnt_r     <= 8'd0;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wmask <= wmask_s;
              mem_wdata <= wdata_s;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            state_r   <= DONE;
            done      <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wmask <= 4'b0000;
            if (!is_store_r) begin
              load_data <= load_ext_s;
            end
          end else if (cnt_r == TIMEOUT_LAST) begin
            state_r     <= DONE;
            done        <= 1'b1;
            fault       <= 1'b1;
            fault_cause <= 2'b11;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_wmask   <= 4'b0000;
            if (!is_store_r) begin
              load_data <= 32'h0000_0000;
            end
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        DONE: begin
          state_r     <= IDLE;
          cnt_r       <= 8'd0;
          busy        <= 1'b0;
          done        <= 1'b0;
          fault       <= 1'b0;
          fault_cause <= 2'b00;
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= 8'd0;
          busy        <= 1'b0;
          done        <= 1'b0;
          fault       <= 1'b0;
          fault_cause <= 2'b00;
          mem_req     <= 1'b0;
          mem_we      <= 1'b0;
          mem_wmask   <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push expected completions
// and bus beats; a negedge monitor pops and compares them.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        fault;
  logic [1:0]  fault_cause;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  typedef struct {
    logic [31:0] a;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic        f;
    logic [1:0]  c;
    logic [31:0] ld;
  } cmp_t;

  bus_t bus_q[$];
  cmp_t cmp_q[$];

  int          n_vec;
  int          n_fail;
  int          ack_after;
  logic [31:0] rdata_cfg;
  logic        late_ack;
  int          req_run;
  int          req_total;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .busy(busy), .done(done), .load_data(load_data),
    .fault(fault), .fault_cause(fault_cause),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory responder: acks on the ack_after-th consecutive request cycle.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    req_run   = 0;
    req_total = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        req_run++;
        req_total++;
      end else begin
        req_run = 0;
      end
      mem_ack   = (mem_req && ack_after != 0 && req_run == ack_after) || late_ack;
      mem_rdata = rdata_cfg;
    end
  end

  // Monitor: bus beats must match the expected request every cycle; completions pop the scoreboard.
  always @(negedge clk) begin
    if (mem_req) begin
      if (bus_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_req: got mem_req=1 addr 0x%08h, expected no request", mem_addr);
      end else begin
        check("mem_addr", mem_addr, bus_q[0].a);
        check("mem_we", {31'd0, mem_we}, {31'd0, bus_q[0].we});
        check("mem_wmask", {28'd0, mem_wmask}, {28'd0, bus_q[0].mask});
        if (bus_q[0].we) check("mem_wdata", mem_wdata, bus_q[0].wdata);
        if (mem_ack) void'(bus_q.pop_front());
      end
    end
    if (done) begin
      if (cmp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected no completion");
      end else begin
        cmp_t e;
        e = cmp_q.pop_front();
        check("fault", {31'd0, fault}, {31'd0, e.f});
        check("fault_cause", {30'd0, fault_cause}, {30'd0, e.c});
        check("load_data", load_data, e.ld);
        check("busy_at_done", {31'd0, busy}, 32'd1);
        if (fault_cause == 2'b11 && bus_q.size() > 0) void'(bus_q.pop_front());
      end
    end
  end

  task automatic do_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input int ack_k, input logic [31:0] rd,
                           input logic ef, input logic [1:0] ec, input logic [31:0] eld,
                           input int exp_lat, input int exp_reqs,
                           input logic [3:0] emask, input logic [31:0] ewdata);
    int   reqs0;
    int   lat;
    logic got;
    if (exp_reqs > 0) bus_q.push_back('{a: {a[31:2], 2'b00}, we: st, mask: emask, wdata: ewdata});
    cmp_q.push_back('{f: ef, c: ec, ld: eld});
    ack_after  = ack_k;
    rdata_cfg  = rd;
    is_store   = st;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    start      = 1'b1;
    reqs0      = req_total;
    @(posedge clk);
    #2;
    start = 1'b0;
    got   = 1'b0;
    lat   = 0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        lat = c;
      end
    end
    check("done_seen", {31'd0, got}, 32'd1);
    check("latency", lat, exp_lat);
    check("req_cycles", req_total - reqs0, exp_reqs);
    @(posedge clk);
    #2;
  endtask

  initial begin
    int   lat;
    logic got;
    int   reqs0;
    n_vec = 0; n_fail = 0;
    ack_after = 0; rdata_cfg = 32'h0; late_ack = 1'b0;
    reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = 32'h0; store_data = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_fault", {29'd0, fault, fault_cause}, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_wmask", {28'd0, mem_wmask}, 32'd0);

    // st f3 addr store_data ack rdata | fault cause load_data lat reqs mask wdata
    do_access(1'b0, 3'b000, 32'h1003, 32'h0, 1, 32'h80FF_1234, 1'b0, 2'b00, 32'hFFFF_FF80, 2, 1, 4'b0000, 32'h0);
    do_access(1'b0, 3'b100, 32'h1003, 32'h0, 1, 32'h80FF_1234, 1'b0, 2'b00, 32'h0000_0080, 2, 1, 4'b0000, 32'h0);
    do_access(1'b1, 3'b001, 32'h2002, 32'hAAAA_BEEF, 3, 32'h0, 1'b0, 2'b00, 32'h0000_0080, 4, 3, 4'b1100, 32'hBEEF_BEEF);
    do_access(1'b1, 3'b000, 32'h3001, 32'h1122_3344, 1, 32'h0, 1'b0, 2'b00, 32'h0000_0080, 2, 1, 4'b0010, 32'h4444_4444);
    do_access(1'b1, 3'b010, 32'h3004, 32'hCAFE_F00D, 2, 32'h0, 1'b0, 2'b00, 32'h0000_0080, 3, 2, 4'b1111, 32'hCAFE_F00D);
    do_access(1'b0, 3'b001, 32'h3002, 32'h0, 1, 32'h8001_7FFF, 1'b0, 2'b00, 32'hFFFF_8001, 2, 1, 4'b0000, 32'h0);
    do_access(1'b0, 3'b101, 32'h3000, 32'h0, 1, 32'h1234_8765, 1'b0, 2'b00, 32'h0000_8765, 2, 1, 4'b0000, 32'h0);
    do_access(1'b1, 3'b100, 32'h3000, 32'h5555_5555, 1, 32'h0, 1'b1, 2'b10, 32'h0000_8765, 1, 0, 4'b0000, 32'h0);
    do_access(1'b1, 3'b001, 32'h2001, 32'h5555_5555, 1, 32'h0, 1'b1, 2'b01, 32'h0000_8765, 1, 0, 4'b0000, 32'h0);
    do_access(1'b0, 3'b010, 32'h3001, 32'h0, 1, 32'h0, 1'b1, 2'b01, 32'h0000_0000, 1, 0, 4'b0000, 32'h0);
    do_access(1'b0, 3'b010, 32'h5000, 32'h0, 1, 32'h1111_1111, 1'b0, 2'b00, 32'h1111_1111, 2, 1, 4'b0000, 32'h0);
    do_access(1'b0, 3'b011, 32'h3000, 32'h0, 1, 32'h0, 1'b1, 2'b10, 32'h0000_0000, 1, 0, 4'b0000, 32'h0);
    do_access(1'b0, 3'b111, 32'h3001, 32'h0, 1, 32'h0, 1'b1, 2'b10, 32'h0000_0000, 1, 0, 4'b0000, 32'h0);
    do_access(1'b0, 3'b010, 32'h4000, 32'h0, 4, 32'hDEAD_BEEF, 1'b0, 2'b00, 32'hDEAD_BEEF, 5, 4, 4'b0000, 32'h0);
    do_access(1'b0, 3'b010, 32'h4000, 32'h0, 0, 32'h0, 1'b1, 2'b11, 32'h0000_0000, 5, 4, 4'b0000, 32'h0);

    // Back-to-back with start held high; address changes while the first access is busy.
    bus_q.push_back('{a: 32'h6000, we: 1'b0, mask: 4'b0000, wdata: 32'h0});
    cmp_q.push_back('{f: 1'b0, c: 2'b00, ld: 32'h0102_0304});
    ack_after = 2; rdata_cfg = 32'h0102_0304;
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h6000; start = 1'b1;
    reqs0 = req_total;
    @(posedge clk);
    #2;
    addr = 32'h6008;
    bus_q.push_back('{a: 32'h6008, we: 1'b0, mask: 4'b0000, wdata: 32'h0});
    cmp_q.push_back('{f: 1'b0, c: 2'b00, ld: 32'h0102_0304});
    got = 1'b0; lat = 0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        lat = c;
      end
    end
    check("b2b_first_latency", lat, 3);
    @(posedge clk);
    #2;
    check("b2b_idle_no_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk);
    #2;
    start = 1'b0;
    check("b2b_second_req", {31'd0, mem_req}, 32'd1);
    check("b2b_second_addr", mem_addr, 32'h6008);
    got = 1'b0; lat = 0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        lat = c;
      end
    end
    check("b2b_second_latency", lat, 3);
    check("b2b_req_cycles", req_total - reqs0, 4);
    @(posedge clk);
    #2;

    // Reset during the second REQ cycle of a store that never gets acked.
    bus_q.push_back('{a: 32'h5000, we: 1'b1, mask: 4'b1111, wdata: 32'h1234_5678});
    ack_after = 0; is_store = 1'b1; funct3 = 3'b010; addr = 32'h5000;
    store_data = 32'h1234_5678; start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    bus_q.delete();
    check("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    late_ack = 1'b1;
    @(posedge clk);
    #2;
    late_ack = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("late_ack_busy", {31'd0, busy}, 32'd0);
    check("late_ack_mem_req", {31'd0, mem_req}, 32'd0);
    check("late_ack_load_data", load_data, 32'd0);
    do_access(1'b0, 3'b010, 32'h7000, 32'h0, 1, 32'h0BAD_F00D, 1'b0, 2'b00, 32'h0BAD_F00D, 2, 1, 4'b0000, 32'h0);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", cmp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the RV32I ALU. Consumes the ALU sum (rs1+imm) as the effective address.
- Performs LB/LH/LW/LBU/LHU/SB/SH/SW over a word-wide req/ack memory port.
- Handles byte-lane steering, write masks, load sign/zero extension, misalignment, illegal-size and bus-timeout faults.
- Multi-cycle; the core stalls while busy=1.

Parameters:
TIMEOUT_CYCLES, 16, number of REQ cycles without mem_ack before a timeout fault (legal range 1..255).

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  launch one access (sampled in IDLE only)
is_store  input  1  1=store, 0=load
funct3  input  3  RV32I load/store funct3
addr  input  32  effective address (ALU result)
store_data  input  32  rs2 value
busy  output  1  access in progress (REQ or DONE)
done  output  1  one-cycle completion pulse
load_data  output  32  extended load result, held until the next completed load
fault  output  1  completion carries an error (valid with done)
fault_cause  output  2  00 none, 01 misaligned, 10 illegal funct3, 11 timeout
mem_req  output  1  memory request, held until ack
mem_we  output  1  write enable
mem_addr  output  32  word address {addr[31:2],2'b00}
mem_wmask  output  4  byte-lane write strobes
mem_wdata  output  32  lane-replicated store data
mem_ack  input  1  memory completion, sampled only while mem_req=1
mem_rdata  input  32  read word, valid in the mem_ack cycle

Behaviour:
- Reset (synchronous, active-high) forces IDLE and zeroes every output and the timeout counter.
  - Takes effect on the edge where reset=1, including mid-REQ. mem_req is low in the following cycle.
  - An ack arriving later is ignored.
- States: IDLE, REQ, DONE.
- IDLE:
  - start=1 captures is_store, funct3, addr, store_data.
  - Legal, aligned access -> REQ.
  - Otherwise -> DONE with fault=1 and no memory access.
- Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000, 001, 010. All other codes -> illegal (cause 10).
- Misaligned (cause 01): halfword with addr[0]=1, or word with addr[1:0]!=0. Illegal takes priority over misaligned.
- REQ:
  - mem_req=1 with mem_addr, mem_we, mem_wmask, mem_wdata stable every cycle.
  - The timeout counter increments each REQ cycle without an ack.
  - mem_ack=1 -> DONE.
  - Counter reaching TIMEOUT_CYCLES without an ack -> DONE with cause 11. If ack and expiry coincide, ack wins.
- Write lanes:
  - SB: mask=1<<addr[1:0], wdata={4{store_data[7:0]}}.
  - SH: mask=0011 (addr[1]=0) or 1100, wdata={2{store_data[15:0]}}.
  - SW: mask=1111.
  - Loads: mask=0000, mem_we=0.
- Load extraction on the ack edge:
  - Byte = mem_rdata[8*addr[1:0]+:8]; halfword = mem_rdata[16*addr[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Result registered into load_data.
- DONE: done=1, busy=1, fault/fault_cause valid for this single cycle, then -> IDLE. fault and fault_cause return to 0 in IDLE.
- load_data rules:
  - Updated only by successful loads.
  - Faulted loads set load_data=0.
  - Stores leave it unchanged.
- start while busy=1 is ignored; it is neither queued nor captured.
- Latency: start at cycle T, first mem_req at T+1.
  - Ack at T+k (k>=1) -> done at T+k+1.
  - Fault without access -> done at T+1.
  - The next start is accepted at T+k+2.
- busy=1 from the cycle after an accepted start through the DONE cycle.

Test Plan:
- LB addr=0x1003, mem_rdata=0x80FF_1234, ack in first REQ cycle -> mem_addr=0x1000, done at T+2, load_data=0xFFFF_FF80, fault=0. Repeat as LBU -> 0x0000_0080.
- SH addr=0x2002, store_data=0xAAAA_BEEF, ack after 3 REQ cycles -> mem_we=1, mem_wmask=1100, mem_wdata=0xBEEF_BEEF held 3 cycles, done at T+4, load_data unchanged.
- LW addr=0x3001 -> no mem_req ever, done at T+1 with fault=1, cause=01, load_data=0. funct3=011 load -> cause=10.
- TIMEOUT_CYCLES=4, LW addr=0x4000, no ack -> mem_req high 4 cycles, done with cause=11. Variant with ack on the 4th REQ cycle -> success, fault=0.
- Back-to-back: start held high continuously -> second access captured only at T+k+2. The start issued during REQ leaves no extra memory request.
- reset asserted during the 2nd REQ cycle of a SW -> mem_req=0, busy=0, done never pulses. A late ack has no effect, and a fresh LW completes normally.
